serial_frame_tx: RTL and testbench

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out LSB-first on a single line as start bit, data bits, optional parity and stop bit(s). Bit timing comes from an external one-cycle enable tick, the same bit-rate tick that clocks the receive-side shift and edge-detect logic. This block is the transmit end of the serial link whose receiver detects the start-bit edge and samples the bits.

---
 rtl/serial_frame_tx.sv | 164 ++++++++++++++++
 tb/tb_serial_frame_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Purpose  : Serial frame transmitter. Takes one parallel word over a
//            valid/ready handshake and shifts it out LSB-first on a single
//            line as start bit, data bits, optional parity and stop bit(s).
//            Every bit lasts exactly one period of the external i_en tick.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_BITS  data bits per frame (1..16)
//   PARITY     0 none, 1 even, 2 odd
//   STOP_BITS  stop bits per frame (1 or 2)
// Ports
//   clk      in   rising-edge clock
//   i_sclr   in   synchronous active-high clear, highest priority
//   i_en     in   bit-rate tick, one-cycle pulse per bit period
//   i_valid  in   i_dat holds a word to send
//   i_dat    in   word to transmit (sampled only at the handshake edge)
//   o_ready  out  block can accept a word this cycle (IDLE only)
//   o_txd    out  registered serial line, idle high
//   o_busy   out  a frame is pending or in flight
//   o_done   out  one-cycle pulse after the last stop bit completes
// ============================================================================
module serial_frame_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 i_sclr,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_dat,
  output logic                 o_ready,
  output logic                 o_txd,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  // One counter serves both the data-bit count and the stop-bit count.
  localparam logic [4:0] C_LAST_DATA = 5'(DATA_BITS - 1);
  localparam logic [4:0] C_LAST_STOP = 5'(STOP_BITS - 1);

  state_t               r_state, w_state_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [4:0]           r_cnt,   w_cnt_n;
  logic                 r_par,   w_par_n;
  logic                 r_txd,   w_txd_n;
  logic                 r_done,  w_done_n;
  logic [DATA_BITS-1:0] w_shift_dn;

  assign w_shift_dn = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_cnt   <= w_cnt_n;
      r_par   <= w_par_n;
      r_txd   <= w_txd_n;
      r_done  <= w_done_n;
    end
  end

  // The line level is computed for the state being entered, so the output
  // register presents each bit in the same cycle its state begins.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_cnt_n   = r_cnt;
    w_par_n   = r_par;
    w_txd_n   = r_txd;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_n = 1'b1;
        if (i_valid) begin
          w_shift_n = i_dat;
          w_par_n   = (PARITY == 2) ? ~^i_dat : ^i_dat;
          w_cnt_n   = '0;
          w_state_n = S_SYNC;
        end
      end
      S_SYNC: begin
        if (i_en) begin
          w_state_n = S_START;
          w_txd_n   = 1'b0;
        end
      end
      S_START: begin
        if (i_en) begin
          w_state_n = S_DATA;
          w_txd_n   = r_shift[0];
          w_cnt_n   = '0;
        end
      end
      S_DATA: begin
        if (i_en) begin
          if (r_cnt == C_LAST_DATA) begin
            w_cnt_n = '0;
            if (PARITY != 0) begin
              w_state_n = S_PARITY;
              w_txd_n   = r_par;
            end else begin
              w_state_n = S_STOP;
              w_txd_n   = 1'b1;
            end
          end else begin
            w_shift_n = w_shift_dn;
            w_cnt_n   = r_cnt + 5'd1;
            w_txd_n   = w_shift_dn[0];
          end
        end
      end
      S_PARITY: begin
        if (i_en) begin
          w_state_n = S_STOP;
          w_txd_n   = 1'b1;
          w_cnt_n   = '0;
        end
      end
      S_STOP: begin
        if (i_en) begin
          if (r_cnt == C_LAST_STOP) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_done_n  = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 5'd1;
          end
          w_txd_n = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_txd_n   = 1'b1;
      end
    endcase
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_busy  = (r_state != S_IDLE);
  assign o_txd   = r_txd;
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Purpose  : Self-checking bench for serial_frame_tx. Three instances cover
//            no parity / 1 stop, even parity / 2 stops, odd parity / 2 stops.
//            A frame-level reference model (bit list per accepted word) is
//            compared against every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       sclr, en, valid;
  logic [7:0] dat;
  logic       txd [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       dne [3];

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: en every cycle, 1: every 4th cycle, 2: random
  bit started = 1'b0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .i_sclr(sclr), .i_en(en), .i_valid(valid), .i_dat(dat),
    .o_ready(rdy[0]), .o_txd(txd[0]), .o_busy(bsy[0]), .o_done(dne[0]));
  serial_frame_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .i_sclr(sclr), .i_en(en), .i_valid(valid), .i_dat(dat),
    .o_ready(rdy[1]), .o_txd(txd[1]), .o_busy(bsy[1]), .o_done(dne[1]));
  serial_frame_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .i_sclr(sclr), .i_en(en), .i_valid(valid), .i_dat(dat),
    .o_ready(rdy[2]), .o_txd(txd[2]), .o_busy(bsy[2]), .o_done(dne[2]));

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         pm [3] = '{0, 1, 2};
  int         sb [3] = '{1, 2, 2};
  logic [31:0] fr [3];
  int         flen [3];
  int         fidx [3];
  bit         mbusy [3] = '{0, 0, 0};
  bit         mline [3] = '{1, 1, 1};
  bit         mdone [3] = '{0, 0, 0};

  // Whole frame as a bit list, index 0 goes on the line first.
  function automatic logic [31:0] build(input logic [7:0] d, input int p,
                                        input int s, output int len);
    logic [31:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      f[n] = d[i];
      n++;
    end
    if (p != 0) begin
      f[n] = (p == 1) ? ^d : ~^d;
      n++;
    end
    n += s;
    len = n;
    return f;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sclr) begin
        mbusy[k] = 0; mline[k] = 1; mdone[k] = 0;
      end else begin
        mdone[k] = 0;
        if (!mbusy[k]) begin
          if (valid) begin
            fr[k] = build(dat, pm[k], sb[k], flen[k]);
            fidx[k] = 0;
            mbusy[k] = 1;
          end
        end else if (en) begin
          if (fidx[k] < flen[k]) begin
            mline[k] = fr[k][fidx[k]];
            fidx[k]++;
          end else begin
            mbusy[k] = 0; mdone[k] = 1; mline[k] = 1;
          end
        end
      end
    end
    started = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("txd%0d", k),   txd[k], mline[k]);
        check($sformatf("ready%0d", k), rdy[k], !mbusy[k]);
        check($sformatf("busy%0d", k),  bsy[k], mbusy[k]);
        check($sformatf("done%0d", k),  dne[k], mdone[k]);
      end
    end
  end

  // ---------------- tick generator ----------------
  initial begin
    int cyc;
    cyc = 0;
    en = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       en = 1'b1;
        1:       en = (cyc % 4 == 0);
        default: en = ($urandom % 3 == 0);
      endcase
      cyc++;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bsy[0] || bsy[1] || bsy[2]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < budget), 1'b1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic s0 [14];
    logic s1 [14];
    logic s2 [14];
    logic d0 [14];
    logic d1 [14];
    int   exp0 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int   low, n, ndone;

    sclr = 1'b1; valid = 1'b0; dat = 8'h00;
    @(negedge clk);
    @(negedge clk);
    sclr = 1'b0;
    check("reset_txd", txd[0], 1'b1);
    check("reset_ready", rdy[0], 1'b1);
    check("reset_busy", bsy[0], 1'b0);
    check("reset_done", dne[0], 1'b0);

    // Frame 0xA5 with a tick every cycle on all three configurations.
    valid = 1'b1; dat = 8'hA5;
    @(negedge clk);
    valid = 1'b0;
    check("a5_busy_after_accept", bsy[0], 1'b1);
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      s0[j] = txd[0]; s1[j] = txd[1]; s2[j] = txd[2];
      d0[j] = dne[0]; d1[j] = dne[1];
    end
    for (int j = 1; j <= 10; j++)
      check($sformatf("a5_bit_edge%0d", j), s0[j], exp0[j-1][0]);
    check("a5_done_edge10", d0[10], 1'b0);
    check("a5_done_edge11", d0[11], 1'b1);
    check("a5_done_edge12", d0[12], 1'b0);
    check("even_d7", s1[9], 1'b1);
    check("even_parity", s1[10], 1'b0);
    check("odd_parity", s2[10], 1'b1);
    check("even_stop1", s1[11], 1'b1);
    check("even_stop2", s1[12], 1'b1);
    check("even_done_edge12", d1[12], 1'b0);
    check("even_done_edge13", d1[13], 1'b1);
    wait_idle(50);

    // Tick every 4th cycle, word 0x3C: start+D0+D1+D6+D7 low -> 20 cycles.
    mode = 1;
    @(negedge clk);
    valid = 1'b1; dat = 8'h3C;
    @(negedge clk);
    valid = 1'b0;
    low = 0; n = 0;
    while (!dne[0] && n < 200) begin
      @(negedge clk);
      if (!txd[0]) low++;
      n++;
    end
    check("3c_done_seen", dne[0], 1'b1);
    check_int("3c_low_cycles", low, 20);
    wait_idle(200);

    // Hold valid with a changing word: later words wait for the done cycle.
    mode = 0;
    valid = 1'b1;
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      dat = 8'($urandom);
      @(negedge clk);
      if (dne[0]) ndone++;
    end
    valid = 1'b0;
    check_int("held_valid_done_count", ndone, 3);
    wait_idle(50);

    // Clear in the middle of D3 of 0xFF.
    valid = 1'b1; dat = 8'hFF;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    check("ff_d3", txd[0], 1'b1);
    check("ff_d3_busy", bsy[0], 1'b1);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check("clr_txd", txd[0], 1'b1);
    check("clr_ready", rdy[0], 1'b1);
    check("clr_done", dne[0], 1'b0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (dne[0]) ndone++;
    end
    check_int("clr_no_done", ndone, 0);
    valid = 1'b1; dat = 8'h00;
    @(negedge clk);
    valid = 1'b0;
    wait_idle(50);

    // Clear coincident with handshake and tick.
    sclr = 1'b1; valid = 1'b1; dat = 8'h5A;
    @(negedge clk);
    sclr = 1'b0; valid = 1'b0;
    check("clr_hs_ready", rdy[0], 1'b1);
    check("clr_hs_busy", bsy[0], 1'b0);
    check("clr_hs_txd", txd[0], 1'b1);
    @(negedge clk);
    check("clr_hs_still_idle", bsy[0], 1'b0);

    // Random traffic with random ticks and occasional clears.
    mode = 2;
    for (int j = 0; j < 4000; j++) begin
      valid = ($urandom % 4 != 0);
      dat   = 8'($urandom);
      sclr  = ($urandom % 64 == 0);
      @(negedge clk);
    end
    sclr = 1'b0; valid = 1'b0; mode = 0;
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
